// File: rtl/pcnn_seq.sv
// Control sequencer for the pcnn convolution datapath: loads image and kernel,
// walks every output window driving MAC/accumulator controls, then streams results.
module pcnn_seq #(
    parameter int AS = 6,
    parameter int BS = 3,
    parameter int AW = 6,
    parameter int KW = 4,
    parameter int OW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          go,
    output logic          img_we,
    output logic [AW-1:0] img_waddr,
    output logic          ker_we,
    output logic [KW-1:0] ker_waddr,
    output logic [AW-1:0] img_raddr,
    output logic [KW-1:0] ker_raddr,
    output logic          mac_en,
    output logic          mac_clr,
    output logic          acc_we,
    output logic [OW-1:0] acc_waddr,
    output logic          out_rd,
    output logic [OW-1:0] out_raddr,
    output logic          busy,
    output logic          done
);

    localparam int OS = AS - BS + 1;
    // The linear counter serves all three streaming phases; the image load is the longest.
    localparam int CW = $clog2(AS * AS + 1);
    localparam int RW = $clog2(AS + 1);

    localparam logic [CW-1:0] A_LAST = CW'(AS * AS - 1);
    localparam logic [CW-1:0] B_LAST = CW'(BS * BS - 1);
    localparam logic [CW-1:0] O_LAST = CW'(OS * OS - 1);
    localparam logic [RW-1:0] K_LAST = RW'(BS - 1);
    localparam logic [RW-1:0] W_LAST = RW'(OS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_A,
        S_LOAD_B,
        S_MAC,
        S_STALL,
        S_CLEAR,
        S_OUT,
        S_DONE
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [RW-1:0] kr_q, kc_q;
    logic [RW-1:0] orow_q, ocol_q;
    logic          mac_en_q;

    // NOTE: every register here updates with <= so all next-state terms see the old values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            kr_q     <= '0;
            kc_q     <= '0;
            orow_q   <= '0;
            ocol_q   <= '0;
            mac_en_q <= 1'b0;
        end else begin
            // One-cycle delay lines mac_en up with the buffers' read latency.
            mac_en_q <= (state_q == S_MAC);
            case (state_q)
                S_IDLE: begin
                    if (go) state_q <= S_LOAD_A;
                end
                S_LOAD_A: begin
                    if (cnt_q == A_LAST) begin
                        cnt_q   <= '0;
                        state_q <= S_LOAD_B;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_LOAD_B: begin
                    if (cnt_q == B_LAST) begin
                        cnt_q   <= '0;
                        state_q <= S_MAC;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_MAC: begin
                    // The last tap is left in kr/kc so read addresses hold through STALL.
                    if (kc_q == K_LAST) begin
                        if (kr_q == K_LAST) begin
                            state_q <= S_STALL;
                        end else begin
                            kc_q <= '0;
                            kr_q <= kr_q + RW'(1);
                        end
                    end else begin
                        kc_q <= kc_q + RW'(1);
                    end
                end
                S_STALL: begin
                    state_q <= S_CLEAR;
                end
                S_CLEAR: begin
                    kr_q <= '0;
                    kc_q <= '0;
                    if (ocol_q == W_LAST) begin
                        ocol_q <= '0;
                        if (orow_q == W_LAST) begin
                            orow_q  <= '0;
                            state_q <= S_OUT;
                        end else begin
                            orow_q  <= orow_q + RW'(1);
                            state_q <= S_MAC;
                        end
                    end else begin
                        ocol_q  <= ocol_q + RW'(1);
                        state_q <= S_MAC;
                    end
                end
                S_OUT: begin
                    if (cnt_q == O_LAST) begin
                        cnt_q   <= '0;
                        state_q <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_DONE: begin
                    if (!go) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign img_we    = (state_q == S_LOAD_A);
    assign img_waddr = img_we ? AW'(cnt_q) : '0;
    assign ker_we    = (state_q == S_LOAD_B);
    assign ker_waddr = ker_we ? KW'(cnt_q) : '0;

    assign img_raddr = (AW'(orow_q) + AW'(kr_q)) * AW'(AS) + AW'(ocol_q) + AW'(kc_q);
    assign ker_raddr = KW'(kr_q) * KW'(BS) + KW'(kc_q);

    assign mac_en    = mac_en_q;
    assign mac_clr   = (state_q == S_CLEAR);
    assign acc_we    = (state_q == S_CLEAR);
    assign acc_waddr = acc_we ? OW'(orow_q) * OW'(OS) + OW'(ocol_q) : '0;

    assign out_rd    = (state_q == S_OUT);
    assign out_raddr = out_rd ? OW'(cnt_q) : '0;

    assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_pcnn_seq.sv
// Directed bench for pcnn_seq: reset, full default run against a cycle model,
// window address vectors, mid-run abort, and two alternative parameter sets.
module tb_pcnn_seq;

    localparam int TAS  = 6;
    localparam int TBS  = 3;
    localparam int TOS  = TAS - TBS + 1;
    localparam int NA   = TAS * TAS;
    localparam int NB   = TBS * TBS;
    localparam int NO   = TOS * TOS;
    localparam int T_W  = NA + NB;
    localparam int T_O  = T_W + (NB + 2) * NO;
    localparam int T_D  = T_O + NO + 1;
    localparam int TMAX = 250;

    typedef struct packed {
        logic       img_we;
        logic [5:0] img_waddr;
        logic       ker_we;
        logic [3:0] ker_waddr;
        logic [5:0] img_raddr;
        logic [3:0] ker_raddr;
        logic       mac_en;
        logic       mac_clr;
        logic       acc_we;
        logic [3:0] acc_waddr;
        logic       out_rd;
        logic [3:0] out_raddr;
        logic       busy;
        logic       done;
    } outs_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic go = 1'b0;
    logic go_b = 1'b0;
    logic go_c = 1'b0;

    logic       img_we, ker_we, mac_en, mac_clr, acc_we, out_rd, busy, done;
    logic [5:0] img_waddr, img_raddr;
    logic [3:0] ker_waddr, ker_raddr, acc_waddr, out_raddr;

    logic       img_we_b, ker_we_b, mac_en_b, mac_clr_b, acc_we_b, out_rd_b, busy_b, done_b;
    logic [3:0] img_waddr_b, img_raddr_b, ker_waddr_b, ker_raddr_b;
    logic [0:0] acc_waddr_b, out_raddr_b;

    logic       img_we_c, ker_we_c, mac_en_c, mac_clr_c, acc_we_c, out_rd_c, busy_c, done_c;
    logic [4:0] img_waddr_c, img_raddr_c;
    logic [1:0] ker_waddr_c, ker_raddr_c;
    logic [3:0] acc_waddr_c, out_raddr_c;

    int checks = 0;
    int failures = 0;
    outs_t rec [0:TMAX];

    always #5 clk = ~clk;

    pcnn_seq #(.AS(6), .BS(3), .AW(6), .KW(4), .OW(4)) dut (
        .clk(clk), .reset(reset), .go(go),
        .img_we(img_we), .img_waddr(img_waddr), .ker_we(ker_we), .ker_waddr(ker_waddr),
        .img_raddr(img_raddr), .ker_raddr(ker_raddr), .mac_en(mac_en), .mac_clr(mac_clr),
        .acc_we(acc_we), .acc_waddr(acc_waddr), .out_rd(out_rd), .out_raddr(out_raddr),
        .busy(busy), .done(done)
    );

    pcnn_seq #(.AS(4), .BS(4), .AW(4), .KW(4), .OW(1)) dut_b (
        .clk(clk), .reset(reset), .go(go_b),
        .img_we(img_we_b), .img_waddr(img_waddr_b), .ker_we(ker_we_b), .ker_waddr(ker_waddr_b),
        .img_raddr(img_raddr_b), .ker_raddr(ker_raddr_b), .mac_en(mac_en_b), .mac_clr(mac_clr_b),
        .acc_we(acc_we_b), .acc_waddr(acc_waddr_b), .out_rd(out_rd_b), .out_raddr(out_raddr_b),
        .busy(busy_b), .done(done_b)
    );

    pcnn_seq #(.AS(5), .BS(2), .AW(5), .KW(2), .OW(4)) dut_c (
        .clk(clk), .reset(reset), .go(go_c),
        .img_we(img_we_c), .img_waddr(img_waddr_c), .ker_we(ker_we_c), .ker_waddr(ker_waddr_c),
        .img_raddr(img_raddr_c), .ker_raddr(ker_raddr_c), .mac_en(mac_en_c), .mac_clr(mac_clr_c),
        .acc_we(acc_we_c), .acc_waddr(acc_waddr_c), .out_rd(out_rd_c), .out_raddr(out_raddr_c),
        .busy(busy_c), .done(done_c)
    );

    function automatic outs_t sample_a();
        outs_t s;
        s.img_we    = img_we;
        s.img_waddr = img_waddr;
        s.ker_we    = ker_we;
        s.ker_waddr = ker_waddr;
        s.img_raddr = img_raddr;
        s.ker_raddr = ker_raddr;
        s.mac_en    = mac_en;
        s.mac_clr   = mac_clr;
        s.acc_we    = acc_we;
        s.acc_waddr = acc_waddr;
        s.out_rd    = out_rd;
        s.out_raddr = out_raddr;
        s.busy      = busy;
        s.done      = done;
        return s;
    endfunction

    // Expected outputs t edges into a run, counting the edge that samples go as t=1.
    function automatic outs_t model(input int t, input bit held, output bit rd_care);
        outs_t e;
        int u, w, p, orow, ocol, kr, kc;
        e = '0;
        rd_care = 1'b0;
        if (t >= 1 && t <= NA) begin
            e.img_we = 1'b1;
            e.img_waddr = 6'(t - 1);
            e.busy = 1'b1;
        end else if (t > NA && t <= T_W) begin
            e.ker_we = 1'b1;
            e.ker_waddr = 4'(t - NA - 1);
            e.busy = 1'b1;
        end else if (t > T_W && t <= T_O) begin
            u = t - T_W - 1;
            w = u / (NB + 2);
            p = u % (NB + 2);
            orow = w / TOS;
            ocol = w % TOS;
            e.busy = 1'b1;
            if (p <= NB) begin
                kr = (p < NB) ? p / TBS : TBS - 1;
                kc = (p < NB) ? p % TBS : TBS - 1;
                e.img_raddr = 6'((orow + kr) * TAS + ocol + kc);
                e.ker_raddr = 4'(kr * TBS + kc);
                e.mac_en = (p >= 1);
                rd_care = 1'b1;
            end else begin
                e.acc_we = 1'b1;
                e.mac_clr = 1'b1;
                e.acc_waddr = 4'(w);
            end
        end else if (t > T_O && t < T_D) begin
            e.out_rd = 1'b1;
            e.out_raddr = 4'(t - T_O - 1);
            e.busy = 1'b1;
        end else if (t == T_D || (t > T_D && held)) begin
            e.done = 1'b1;
        end
        return e;
    endfunction

    function automatic outs_t mask(input outs_t o, input outs_t e, input bit rd_care);
        outs_t m;
        m = o;
        if (!e.img_we) m.img_waddr = '0;
        if (!e.ker_we) m.ker_waddr = '0;
        if (!rd_care) begin
            m.img_raddr = '0;
            m.ker_raddr = '0;
        end
        if (!e.acc_we) m.acc_waddr = '0;
        if (!e.out_rd) m.out_raddr = '0;
        return m;
    endfunction

    // Called at a negedge; drives go and records n cycles into rec[1..n].
    task automatic run_record(input bit held, input int n);
        go = 1'b1;
        for (int t = 1; t <= n; t++) begin
            @(negedge clk);
            rec[t] = sample_a();
            if (!held && t == 1) go = 1'b0;
        end
    endtask

    task automatic test_reset();
        outs_t o;
        reset = 1'b0;
        go = 1'b1;
        repeat (3) @(negedge clk);
        o = sample_a();
        checks++;
        if (o !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%h want=0", o);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy got=%b want=0", busy);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (img_we !== 1'b1 || img_waddr !== 6'd0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL release_load_a got we=%b addr=%0d busy=%b want 1/0/1",
                     img_we, img_waddr, busy);
        end
        reset = 1'b0;
        go = 1'b0;
        #1;
        o = sample_a();
        checks++;
        if (o !== '0) begin
            failures++;
            $display("FAIL reset_async got=%h want=0", o);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_full_run();
        outs_t e, o;
        bit rc;
        int first_done;
        run_record(1'b1, 240);
        first_done = -1;
        for (int t = 1; t <= 240; t++) begin
            e = model(t, 1'b1, rc);
            o = mask(rec[t], e, rc);
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL full_run t=%0d got=%h want=%h", t, o, e);
            end
            if (rec[t].done && first_done < 0) first_done = t;
        end
        checks++;
        if (first_done != T_D) begin
            failures++;
            $display("FAIL done_edge got=%0d want=%0d", first_done, T_D);
        end
        go = 1'b0;
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL go_drop_idle got done=%b busy=%b want 0/0", done, busy);
        end
    endtask

    // Inspects the trace left by test_full_run against hand-written vectors.
    task automatic test_windows();
        int first_img [9] = '{0, 1, 2, 6, 7, 8, 12, 13, 14};
        int last_img  [9] = '{21, 22, 23, 27, 28, 29, 33, 34, 35};
        int n_img, n_ker, n_acc, n_out, n_mac, bad_seq;
        for (int j = 0; j < 9; j++) begin
            checks++;
            if (rec[46 + j].img_raddr !== 6'(first_img[j]) || rec[46 + j].ker_raddr !== 4'(j)) begin
                failures++;
                $display("FAIL first_window tap=%0d got img=%0d ker=%0d want img=%0d ker=%0d",
                         j, rec[46 + j].img_raddr, rec[46 + j].ker_raddr, first_img[j], j);
            end
            checks++;
            if (rec[211 + j].img_raddr !== 6'(last_img[j])) begin
                failures++;
                $display("FAIL last_window tap=%0d got=%0d want=%0d",
                         j, rec[211 + j].img_raddr, last_img[j]);
            end
        end
        n_mac = 0;
        for (int t = 46; t <= 56; t++) if (rec[t].mac_en) n_mac++;
        checks++;
        if (n_mac != 9 || rec[46].mac_en !== 1'b0 || rec[47].mac_en !== 1'b1 || rec[55].mac_en !== 1'b1) begin
            failures++;
            $display("FAIL first_mac_en got count=%0d want 9 over t=47..55", n_mac);
        end
        checks++;
        if (rec[56].acc_we !== 1'b1 || rec[56].mac_clr !== 1'b1 || rec[56].acc_waddr !== 4'd0) begin
            failures++;
            $display("FAIL first_clear got we=%b clr=%b addr=%0d want 1/1/0",
                     rec[56].acc_we, rec[56].mac_clr, rec[56].acc_waddr);
        end
        n_img = 0; n_ker = 0; n_acc = 0; n_out = 0; bad_seq = 0;
        for (int t = 1; t <= 240; t++) begin
            if (rec[t].img_we) begin
                if (rec[t].img_waddr !== 6'(n_img)) bad_seq++;
                n_img++;
            end
            if (rec[t].ker_we) begin
                if (rec[t].ker_waddr !== 4'(n_ker)) bad_seq++;
                n_ker++;
            end
            if (rec[t].acc_we) begin
                if (rec[t].acc_waddr !== 4'(n_acc)) bad_seq++;
                n_acc++;
            end
            if (rec[t].out_rd) begin
                if (rec[t].out_raddr !== 4'(n_out)) bad_seq++;
                n_out++;
            end
        end
        checks++;
        if (n_img != 36 || n_ker != 9) begin
            failures++;
            $display("FAIL load_counts got img=%0d ker=%0d want 36/9", n_img, n_ker);
        end
        checks++;
        if (n_acc != 16 || n_out != 16) begin
            failures++;
            $display("FAIL window_counts got acc=%0d out=%0d want 16/16", n_acc, n_out);
        end
        checks++;
        if (bad_seq != 0) begin
            failures++;
            $display("FAIL address_order got %0d out-of-order want 0", bad_seq);
        end
    endtask

    task automatic test_reset_mid_run();
        outs_t e, o;
        bit rc;
        int n_done, n_acc;
        go = 1'b1;
        for (int t = 1; t <= 93; t++) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || img_raddr !== 6'd12 || ker_raddr !== 4'd3) begin
            failures++;
            $display("FAIL window5_tap3 got busy=%b img=%0d ker=%0d want 1/12/3",
                     busy, img_raddr, ker_raddr);
        end
        #2;
        reset = 1'b0;
        go = 1'b0;
        #1;
        o = sample_a();
        checks++;
        if (o !== '0) begin
            failures++;
            $display("FAIL abort_outputs got=%h want=0", o);
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || img_we !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_abort got busy=%b done=%b we=%b want 0/0/0",
                     busy, done, img_we);
        end
        run_record(1'b0, 245);
        n_done = 0;
        n_acc = 0;
        for (int t = 1; t <= 245; t++) begin
            e = model(t, 1'b0, rc);
            o = mask(rec[t], e, rc);
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL pulse_run t=%0d got=%h want=%h", t, o, e);
            end
            if (rec[t].done) n_done++;
            if (rec[t].acc_we) n_acc++;
        end
        checks++;
        if (n_done != 1 || n_acc != 16) begin
            failures++;
            $display("FAIL pulse_run_counts got done=%0d acc=%0d want 1/16", n_done, n_acc);
        end
    endtask

    task automatic test_param_sweep();
        int db, dc, acc_b, acc_c, mac_b, mac_c, bad_c;
        db = -1; dc = -1; acc_b = 0; acc_c = 0; mac_b = 0; mac_c = 0; bad_c = 0;
        go_b = 1'b1;
        go_c = 1'b1;
        for (int t = 1; t <= 300; t++) begin
            @(negedge clk);
            if (done_b && db < 0) db = t;
            if (done_c && dc < 0) dc = t;
            if (acc_we_b) begin
                acc_b++;
                if (acc_waddr_b !== 1'b0) bad_c++;
            end
            if (acc_we_c) begin
                if (acc_waddr_c !== 4'(acc_c)) bad_c++;
                acc_c++;
            end
            if (mac_en_b) mac_b++;
            if (mac_en_c) mac_c++;
        end
        go_b = 1'b0;
        go_c = 1'b0;
        checks++;
        if (db != 52) begin
            failures++;
            $display("FAIL sweep_b_done got=%0d want=52", db);
        end
        checks++;
        if (acc_b != 1 || mac_b != 16) begin
            failures++;
            $display("FAIL sweep_b_window got acc=%0d mac=%0d want 1/16", acc_b, mac_b);
        end
        checks++;
        if (dc != 142) begin
            failures++;
            $display("FAIL sweep_c_done got=%0d want=142", dc);
        end
        checks++;
        if (acc_c != 16 || mac_c != 64 || bad_c != 0) begin
            failures++;
            $display("FAIL sweep_c_windows got acc=%0d mac=%0d bad=%0d want 16/64/0",
                     acc_c, mac_c, bad_c);
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_full_run();
        test_windows();
        test_reset_mid_run();
        test_param_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
